adder_seq_ctrl: RTL and testbench
=================================

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; legal values are multiples of 4 and at least 4.
REQ-002 SHALL have derived constant NIB = WIDTH/4, the number of nibble steps per operation.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, operand request.
REQ-006 SHALL have port in_ready, output, 1, controller can accept operands.
REQ-007 SHALL have ports a and b, input, WIDTH each, operands.
REQ-008 SHALL have port op, input, 1, 0=add, 1=subtract (a-b); honoured only per REQ-027.
REQ-009 SHALL have port out_valid, output, 1, result available.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port sum, output, WIDTH, result.
REQ-012 SHALL have ports flagN, flagZ, flagC and flagV, output, 1 each, result flags.
REQ-013 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, ADD and DONE.
REQ-015 In IDLE: in_ready=1; a cycle with in_valid=1 is an accept that latches a, b, op and sets nibble index=0, carry=0 (add) or 1 (subtract), and next state=ADD.
REQ-016 In ADD: each cycle adds nibble[idx] of a, nibble[idx] of b (b inverted for subtract) and the carry through one internal 4-bit ripple slice.
REQ-017 In ADD: each cycle writes the 4-bit result into sum nibble idx, registers the slice carry-out, and increments idx.
REQ-018 In ADD: the cycle that processes idx=NIB-1 SHALL also capture the carry into bit 3 of that slice, then set next state=DONE.
REQ-019 In DONE: out_valid=1, with sum and flags stable; a cycle with out_ready=1 completes the operation and sets next state=IDLE.
REQ-020 in_ready SHALL be 0 in ADD and DONE; no second operation is accepted until return to IDLE, so the minimum spacing between accepts is NIB+2 cycles.
REQ-021 Latency: when accepted in cycle T, out_valid SHALL first be high in cycle T+NIB+1 (5 for WIDTH=16).
REQ-022 flagZ SHALL equal (sum==0), flagN SHALL equal sum[WIDTH-1], and flagC SHALL equal the final carry-out (for subtract, 1 means no borrow).
REQ-023 flagV SHALL equal the carry into the MSB XOR the final carry-out; all four flags are independent and may be set together.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH, and the carry into nibble 0 SHALL be only the op-derived initial carry.
REQ-025 Inputs a, b and op SHALL be ignored outside the accept cycle, and changes during ADD or DONE SHALL NOT affect the result.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL enter IDLE with sum, all flags, carry and idx cleared, out_valid=0 and busy=0; in_ready is 1 from the first cycle after reset, and any in-flight operation, including one in ADD or DONE, is discarded with no out_valid.

Configuration
REQ-027 Macro ADDSEQ_SUB_EN defined: op=1 SHALL perform a-b via inverted b and initial carry 1; macro undefined: op SHALL be ignored, every operation SHALL be an add, and no inversion logic SHALL be synthesised.

Verification
REQ-028 Add a=0x0001, b=0xFFFF accepted at T -> out_valid at T+5, sum=0x0000, Z=1, C=1, V=0, N=0.
REQ-029 Add 0x7FFF+0x0001 -> sum=0x8000, N=1, V=1, C=0, Z=0; add 0x8000+0x8000 -> sum=0x0000, Z=1, C=1, V=1.
REQ-030 Backpressure: hold out_ready=0 for 3 cycles in DONE -> sum and flags unchanged, in_ready=0; out_ready=1 -> IDLE next cycle and in_ready=1.
REQ-031 Assert rst during the 2nd ADD cycle -> next cycle IDLE, all outputs 0, in_ready=1; a new add 0x0002+0x0003 then returns 0x0005.
REQ-032 With ADDSEQ_SUB_EN: 0x0003-0x0005 -> 0xFFFE, C=0, N=1; 0x0005-0x0005 -> 0x0000, Z=1, C=1. Without the macro: op=1 with 0x0003, 0x0005 -> 0x0008.

Source files
------------

// File: rtl/adder_seq_if.sv
// adder_seq_if: operand/result handshake bundle for adder_seq_ctrl
interface adder_seq_if #(parameter int WIDTH = 16);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic op;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] sum;
  logic flagN;
  logic flagZ;
  logic flagC;
  logic flagV;
  logic busy;
  modport master(output in_valid, a, b, op, out_ready,
                 input in_ready, out_valid, sum, flagN, flagZ, flagC, flagV, busy);
  modport slave(input in_valid, a, b, op, out_ready,
                output in_ready, out_valid, sum, flagN, flagZ, flagC, flagV, busy);
endinterface

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: nibble-serial add (and subtract when ADDSEQ_SUB_EN is defined) with N/Z/C/V flags
module adder_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst,
  adder_seq_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, sum_r, sum_nx;
  logic [IW-1:0] idx;
  logic carry, fn, fz, fc, fv, last, c3;
  logic [4:0] slice;
  assign last = idx == IW'(NIB - 1);
  assign slice = {1'b0, a_r[3:0]} + {1'b0, b_r[3:0]} + {4'b0, carry};
  assign c3 = a_r[3] ^ b_r[3] ^ slice[3];
  always_comb begin
    sum_nx = sum_r;
    for (int i = 0; i < NIB; i++)
      if (idx == IW'(i)) sum_nx[i*4 +: 4] = slice[3:0];
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.in_valid ? ADD : IDLE;
      ADD: state_nx = last ? DONE : ADD;
      DONE: state_nx = bus.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // operands shift right so the active nibble is always bits [3:0]
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      sum_r <= '0;
      idx <= '0;
      carry <= 1'b0;
      {fn, fz, fc, fv} <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.in_valid) begin
        a_r <= bus.a;
        idx <= '0;
`ifdef ADDSEQ_SUB_EN
        b_r <= bus.op ? ~bus.b : bus.b;
        carry <= bus.op;
`else
        b_r <= bus.b;
        carry <= 1'b0;
`endif
      end
      if (state == ADD) begin
        a_r <= a_r >> 4;
        b_r <= b_r >> 4;
        sum_r <= sum_nx;
        carry <= slice[4];
        idx <= idx + 1'b1;
        if (last) {fn, fz, fc, fv} <= {sum_nx[WIDTH-1], sum_nx == '0, slice[4], c3 ^ slice[4]};
      end
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.sum = sum_r;
  assign bus.flagN = fn;
  assign bus.flagZ = fz;
  assign bus.flagC = fc;
  assign bus.flagV = fv;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: random and directed checks of adder_seq_ctrl against an arithmetic model
module tb_adder_seq_ctrl;
  localparam int W = 16;
  localparam int NIB = W / 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_run = 0;
  int n_fail = 0;
  adder_seq_if #(.WIDTH(W)) bus ();
  adder_seq_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    logic [W-1:0] bb;
    logic ci;
    logic [W:0] r;
    logic v;
    bb = b;
    ci = 1'b0;
`ifdef ADDSEQ_SUB_EN
    if (op) begin
      bb = ~b;
      ci = 1'b1;
    end
`endif
    r = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
    v = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    return {r[W-1], r[W-1:0] == '0, r[W], v, r[W-1:0]};
  endfunction

  function automatic logic [W+3:0] observed();
    return {bus.flagN, bus.flagZ, bus.flagC, bus.flagV, bus.sum};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input int hold);
    int n;
    logic [W+3:0] exp;
    exp = model(a, b, op);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_before_accept", bus.in_ready, 1);
    bus.a = a;
    bus.b = b;
    bus.op = op;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.op = 1'($urandom);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      chk("in_ready_while_add", bus.in_ready, 0);
      tick();
      n++;
    end
    chk("latency", n, NIB);
    chk("busy_done", bus.busy, 1);
    chk("result", observed(), exp);
    for (int i = 0; i < hold; i++) begin
      bus.a = W'($urandom);
      tick();
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_result", observed(), exp);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_out_valid", bus.out_valid, 0);
    chk("idle_busy", bus.busy, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.op = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_outputs", observed(), 0);
    do_op(16'h0001, 16'hFFFF, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 3);
    // abort in the second ADD cycle
    bus.a = 16'h1234;
    bus.b = 16'h4321;
    bus.op = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_outputs", observed(), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_valid", bus.out_valid, 0);
    end
    do_op(16'h0002, 16'h0003, 1'b0, 0);
    do_op(16'h0003, 16'h0005, 1'b1, 0);
    do_op(16'h0005, 16'h0005, 1'b1, 1);
    for (int i = 0; i < 40; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
